// File: rtl/fifo_wr_arbiter_pkg.sv
// ============================================================================
// Module      : fifo_wr_arbiter_pkg
// Description : Shared types and constants for the FIFO write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_wr_arbiter_pkg;

    localparam int ARB_N_REQ      = 4;
    localparam int ARB_FIFO_WIDTH = 16;
    localparam int ARB_STALL_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        STALL = 2'd2
    } arb_state_e;

endpackage : fifo_wr_arbiter_pkg

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: masked then unmasked priority encode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] win_onehot,
    output logic [PTR_W-1:0] win_idx
);

    logic [N_REQ-1:0] w_mask;
    logic [N_REQ-1:0] w_masked;

    // Requests at or above the pointer get first choice; below it only on wrap.
    for (genvar i = 0; i < N_REQ; i++) begin : g_mask
        assign w_mask[i] = (PTR_W'(i) >= rr_ptr);
    end

    assign w_masked = req & w_mask;

    always_comb begin
        win_idx    = '0;
        win_onehot = '0;
        if (|w_masked) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (w_masked[i]) begin
                    win_idx = PTR_W'(i);
                end
            end
        end else begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (req[i]) begin
                    win_idx = PTR_W'(i);
                end
            end
        end
        if (|req) begin
            win_onehot[win_idx] = 1'b1;
        end
    end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin sharing of the FIFO write port with flow control,
//               protocol error flag and saturating back-pressure counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ      = ARB_N_REQ,
    parameter int FIFO_WIDTH = ARB_FIFO_WIDTH,
    parameter int STALL_W    = ARB_STALL_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            gnt,
    output logic                        wr_en,
    output logic [FIFO_WIDTH-1:0]       data_in,
    input  logic                        full,
    input  logic                        almostfull,
    input  logic                        wr_ack,
    input  logic                        overflow,
    input  logic                        err_clr,
    output logic                        err,
    output logic [STALL_W-1:0]          stall_cnt
);

    localparam int PTR_W = $clog2(N_REQ);

    arb_state_e              r_state;
    logic [PTR_W-1:0]        r_rr_ptr;
    logic [N_REQ-1:0]        r_gnt;
    logic                    r_wr_en;
    logic                    r_wr_pend;
    logic [FIFO_WIDTH-1:0]   r_data_in;
    logic                    r_err;
    logic [STALL_W-1:0]      r_stall_cnt;

    logic [N_REQ-1:0]        w_win_onehot;
    logic [PTR_W-1:0]        w_win_idx;
    logic [PTR_W-1:0]        w_next_ptr;
    logic [FIFO_WIDTH-1:0]   w_win_data;
    logic                    w_issue;
    logic                    w_blocked;
    logic                    w_err_set;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req        (req),
        .rr_ptr     (r_rr_ptr),
        .win_onehot (w_win_onehot),
        .win_idx    (w_win_idx)
    );

    // A write already in flight against almostfull fills the FIFO, so hold off.
    assign w_issue    = en && (|req) && !full && !(r_wr_en && almostfull);
    assign w_blocked  = en && (|req) && !w_issue;
    assign w_win_data = req_data[w_win_idx*FIFO_WIDTH +: FIFO_WIDTH];
    assign w_next_ptr = (w_win_idx == PTR_W'(N_REQ - 1)) ? '0 : w_win_idx + 1'b1;

    assign w_err_set  = (r_wr_pend && !wr_ack) || (overflow && (r_wr_en || r_wr_pend));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_gnt       <= '0;
            r_wr_en     <= 1'b0;
            r_data_in   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_gnt   <= '0;
            r_wr_en <= 1'b0;
            // Every state follows the same issue/blocked/idle decision.
            case (r_state)
                IDLE, GRANT, STALL: begin
                    if (w_issue) begin
                        r_state   <= GRANT;
                        r_gnt     <= w_win_onehot;
                        r_wr_en   <= 1'b1;
                        r_data_in <= w_win_data;
                        r_rr_ptr  <= w_next_ptr;
                    end else if (w_blocked) begin
                        r_state <= STALL;
                        if (r_stall_cnt != {STALL_W{1'b1}}) begin
                            r_stall_cnt <= r_stall_cnt + 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_pend <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_wr_pend <= r_wr_en;
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign gnt       = r_gnt;
    assign wr_en     = r_wr_en;
    assign data_in   = r_data_in;
    assign err       = r_err;
    assign stall_cnt = r_stall_cnt;

    a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_gnt));
    a_wr_not_full: assert property (@(posedge clk) disable iff (!rst_n) r_wr_en |-> !full);
    a_state_wr   : assert property (@(posedge clk) disable iff (!rst_n) r_wr_en == (r_state == GRANT));

    for (genvar i = 0; i < N_REQ; i++) begin : g_sva_gnt
        a_gnt_req: assert property (@(posedge clk) disable iff (!rst_n) r_gnt[i] |-> $past(req[i]));
    end

endmodule : fifo_wr_arbiter

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench with FIFO model and write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     gnt;
    logic             wr_en;
    logic [W-1:0]     data_in;
    logic             full;
    logic             almostfull;
    logic             wr_ack = 1'b0;
    logic             overflow = 1'b0;
    logic             err_clr;
    logic             err;
    logic [15:0]      stall_cnt;

    int checks = 0;
    int errors = 0;

    int   fifo_count = 0;
    int   fifo_load  = 0;
    logic fifo_load_en = 1'b0;
    logic drain    = 1'b0;
    logic drop_ack = 1'b0;
    logic mon_en   = 1'b0;

    typedef struct {
        int         idx;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] wq[N][$];

    fifo_wr_arbiter #(
        .N_REQ      (N),
        .FIFO_WIDTH (W),
        .STALL_W    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .wr_en      (wr_en),
        .data_in    (data_in),
        .full       (full),
        .almostfull (almostfull),
        .wr_ack     (wr_ack),
        .overflow   (overflow),
        .err_clr    (err_clr),
        .err        (err),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    // FIFO occupancy model: write accepted when not full, optional drain of one word per cycle.
    assign full       = (fifo_count == DEPTH);
    assign almostfull = (fifo_count == DEPTH - 1);

    always @(posedge clk) begin
        if (fifo_load_en) begin
            fifo_count <= fifo_load;
            wr_ack     <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            fifo_count <= fifo_count + ((wr_en && !full) ? 1 : 0) - ((drain && fifo_count > 0) ? 1 : 0);
            wr_ack     <= wr_en && !full && !drop_ack;
            overflow   <= wr_en && full;
        end
    end

    // Scoreboard: each write must match the oldest expected (requester, word).
    exp_t         mon_e;
    logic [N-1:0] mon_one;
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (wr_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_write gnt=%b data_in=%h required no write", gnt, data_in);
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_one = 1;
                    mon_one = mon_one << mon_e.idx;
                    if (gnt !== mon_one || data_in !== mon_e.data) begin
                        errors++;
                        $display("FAIL sb_write gnt=%b data_in=%h required gnt=%b data_in=%h",
                                 gnt, data_in, mon_one, mon_e.data);
                    end
                end
                checks++;
                if (full !== 1'b0) begin
                    errors++;
                    $display("FAIL wr_en_while_full full=%b required 0", full);
                end
            end else begin
                checks++;
                if (gnt !== '0) begin
                    errors++;
                    $display("FAIL gnt_without_wr_en gnt=%b required 0000", gnt);
                end
            end
        end
    end

    task automatic update_req();
        for (int i = 0; i < N; i++) begin
            req[i]            = (wq[i].size() != 0);
            req_data[i*W +: W] = (wq[i].size() != 0) ? wq[i][0] : '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (gnt[i] && wq[i].size() != 0) begin
                void'(wq[i].pop_front());
            end
        end
        update_req();
    endtask

    task automatic push_word(input int idx, input logic [W-1:0] d);
        exp_t e;
        wq[idx].push_back(d);
        e.idx  = idx;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic run_until_done(input int max_cycles, input string name);
        int  n;
        logic busy;
        n    = 0;
        busy = 1'b1;
        while (busy && n < max_cycles) begin
            step();
            n++;
            busy = (exp_q.size() != 0);
            for (int i = 0; i < N; i++) begin
                if (wq[i].size() != 0) busy = 1'b1;
            end
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required 0 within %0d cycles", name, exp_q.size(), max_cycles);
        end
    endtask

    task automatic do_reset(input int level);
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        en       = 1'b1;
        req      = '0;
        req_data = '0;
        err_clr  = 1'b0;
        drop_ack = 1'b0;
        drain    = 1'b0;
        for (int i = 0; i < N; i++) wq[i].delete();
        exp_q.delete();
        fifo_load    = level;
        fifo_load_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        fifo_load_en = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(0);
        checks++;
        if (gnt !== '0 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt_wr gnt=%b wr_en=%b required 0000 0", gnt, wr_en);
        end
        checks++;
        if (data_in !== '0) begin
            errors++;
            $display("FAIL reset_data_in data_in=%h required 0000", data_in);
        end
        checks++;
        if (err !== 1'b0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_err_stall err=%b stall_cnt=%0d required 0 0", err, stall_cnt);
        end
    endtask

    task automatic test_single_stream();
        do_reset(0);
        for (int k = 0; k < 8; k++) push_word(0, 16'hA000 + 16'(k));
        update_req();
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (gnt !== 4'b0001 || wr_en !== 1'b1) begin
                errors++;
                $display("FAIL stream_consecutive_%0d gnt=%b wr_en=%b required 0001 1", k, gnt, wr_en);
            end
        end
        step();
        checks++;
        if (wr_en !== 1'b0 || stall_cnt !== 16'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL stream_end wr_en=%b stall_cnt=%0d err=%b required 0 0 0", wr_en, stall_cnt, err);
        end
        run_until_done(4, "stream");
    endtask

    task automatic test_round_robin();
        do_reset(0);
        drain = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) push_word(i, 16'hB000 + 16'(i * 256) + 16'(k));
        end
        update_req();
        run_until_done(40, "round_robin");
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL rr_err err=%b required 0", err);
        end
    endtask

    task automatic test_almostfull();
        do_reset(DEPTH - 1);
        push_word(1, 16'h3000);
        update_req();
        step();
        checks++;
        if (gnt !== 4'b0010 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL af_first gnt=%b stall_cnt=%0d required 0010 0", gnt, stall_cnt);
        end
        push_word(1, 16'h3001);
        update_req();
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (wr_en !== 1'b0 || stall_cnt !== 16'(k)) begin
                errors++;
                $display("FAIL af_stall_%0d wr_en=%b stall_cnt=%0d required 0 %0d", k, wr_en, stall_cnt, k);
            end
        end
        drain = 1'b1;
        run_until_done(10, "almostfull");
    endtask

    task automatic test_err();
        do_reset(0);
        drain    = 1'b1;
        drop_ack = 1'b1;
        push_word(0, 16'h4000);
        update_req();
        step();
        checks++;
        if (wr_en !== 1'b1) begin
            errors++;
            $display("FAIL err_write wr_en=%b required 1", wr_en);
        end
        step();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_early err=%b required 0", err);
        end
        step();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set err=%b required 1", err);
        end
        drop_ack = 1'b0;
        repeat (3) step();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky err=%b required 1", err);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear err=%b required 0", err);
        end
    endtask

    task automatic test_reset_mid_write();
        int n;
        do_reset(0);
        mon_en = 1'b0;
        drain  = 1'b1;
        req    = 4'b0101;
        req_data[0*W +: W] = 16'h5000;
        req_data[2*W +: W] = 16'h5200;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (gnt === '0 && n < 4);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_first gnt=%b required 0001", gnt);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== '0 || wr_en !== 1'b0 || data_in !== '0 || err !== 1'b0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs gnt=%b wr_en=%b data_in=%h err=%b stall_cnt=%0d required all 0",
                     gnt, wr_en, data_in, err, stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (gnt !== 4'b0001 || data_in !== 16'h5000) begin
            errors++;
            $display("FAIL rst_mid_restart gnt=%b data_in=%h required 0001 5000", gnt, data_in);
        end
        req = '0;
        step();
    endtask

    task automatic test_enable();
        do_reset(0);
        drain = 1'b1;
        en    = 1'b0;
        wq[3].push_back(16'h6000);
        update_req();
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (gnt !== '0 || wr_en !== 1'b0 || stall_cnt !== 16'd0) begin
                errors++;
                $display("FAIL en_off_%0d gnt=%b wr_en=%b stall_cnt=%0d required 0000 0 0", k, gnt, wr_en, stall_cnt);
            end
        end
        begin
            exp_t e;
            e.idx  = 3;
            e.data = 16'h6000;
            exp_q.push_back(e);
        end
        en = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b1000 || data_in !== 16'h6000) begin
            errors++;
            $display("FAIL en_on gnt=%b data_in=%h required 1000 6000", gnt, data_in);
        end
        run_until_done(4, "enable");
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        req      = '0;
        req_data = '0;
        err_clr  = 1'b0;
        test_reset();
        test_single_stream();
        test_round_robin();
        test_almostfull();
        test_err();
        test_reset_mid_write();
        test_enable();
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter

`default_nettype wire
